// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP bus master: command encodings, FSM states,
// port-byte prefixes and the byte-sequencing helpers.
package vdp_pkg;

    typedef enum logic [2:0] {
        OP_WREG  = 3'd0,
        OP_SETW  = 3'd1,
        OP_SETR  = 3'd2,
        OP_WDATA = 3'd3,
        OP_RDATA = 3'd4,
        OP_RSTAT = 3'd5,
        OP_FILL  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        RDHOLD = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam logic [1:0] PFX_WRITE = 2'b01;
    localparam logic [1:0] PFX_READ  = 2'b00;
    localparam logic [4:0] PFX_REG   = 5'b10000;

    // Byte driven onto the VDP port; two-byte ops select their half with 'first'.
    function automatic logic [7:0] port_byte(op_t op, logic [13:0] addr,
                                             logic [7:0] data, logic first);
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_WREG:           b = first ? data : {PFX_REG, addr[2:0]};
            OP_SETW:           b = first ? addr[7:0] : {PFX_WRITE, addr[13:8]};
            OP_SETR:           b = first ? addr[7:0] : {PFX_READ, addr[13:8]};
            OP_WDATA, OP_FILL: b = data;
            default:           b = 8'h00;
        endcase
        return b;
    endfunction

    // Nine bits so that a FILL length of 0 means 256 transfers.
    function automatic logic [8:0] byte_count(op_t op, logic [7:0] len);
        logic [8:0] n;
        n = 9'd0;
        case (op)
            OP_WREG, OP_SETW, OP_SETR:    n = 9'd2;
            OP_WDATA, OP_RDATA, OP_RSTAT: n = 9'd1;
            OP_FILL:                      n = (len == 8'd0) ? 9'd256 : {1'b0, len};
            default:                      n = 9'd0;
        endcase
        return n;
    endfunction

    function automatic logic op_mode(op_t op);
        return (op == OP_WREG) || (op == OP_SETW) || (op == OP_SETR) || (op == OP_RSTAT);
    endfunction

    function automatic logic op_is_read(op_t op);
        return (op == OP_RDATA) || (op == OP_RSTAT);
    endfunction

endpackage

// File: rtl/vdp_bus_master_if.sv
// Command/response handshake plus the VDP-side port pins of the bus master.
interface vdp_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [13:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_len;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        vdp_mode;
    logic [7:0]  vdp_dout;
    logic        vdp_wr;
    logic        vdp_rd;
    logic [7:0]  vdp_din;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, vdp_din,
        output cmd_ready, rsp_valid, rsp_data, vdp_mode, vdp_dout, vdp_wr, vdp_rd
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, vdp_din,
        input  cmd_ready, rsp_valid, rsp_data, vdp_mode, vdp_dout, vdp_wr, vdp_rd
    );
endinterface

// File: rtl/vdp_strobe_timer.sv
// 4-bit down-counter timing the RDHOLD and GAP states; done when it reaches zero.
module vdp_strobe_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);
    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign done = (count_reg == 4'd0);
endmodule

// File: rtl/vdp_bus_master.sv
// Turns WREG/SETW/SETR/WDATA/RDATA/RSTAT/FILL commands into timed VDP port
// byte writes and reads through a SETUP/STROBE|RDHOLD/GAP sequence per byte.
module vdp_bus_master
    import vdp_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int RD_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               reset,
    vdp_bus_master_if.master   bus
);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] RD_LOAD  = 4'(RD_CYCLES - 1);

    state_t      state_reg, state_next;
    op_t         op_reg;
    op_t         cmd_op;
    logic [13:0] addr_reg;
    logic [7:0]  data_reg;
    logic [8:0]  cnt_reg;
    logic        mode_reg;
    logic [7:0]  dout_reg;
    logic        rsp_valid_reg;
    logic [7:0]  rsp_data_reg;
    logic        timer_load;
    logic [3:0]  timer_val;
    logic        timer_done;
    logic        accept;
    logic        rd_last;

    assign cmd_op  = op_t'(bus.cmd_op);
    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign rd_last = (state_reg == RDHOLD) && timer_done;

    vdp_strobe_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = 4'd0;
        case (state_reg)
            IDLE: begin
                // The reserved op is taken and retired here without leaving IDLE.
                if (accept && (cmd_op != OP_RSVD)) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (op_is_read(op_reg)) begin
                    state_next = RDHOLD;
                    timer_load = 1'b1;
                    timer_val  = RD_LOAD;
                end else begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                state_next = GAP;
                timer_load = 1'b1;
                timer_val  = GAP_LOAD;
            end
            RDHOLD: begin
                if (timer_done) begin
                    state_next = GAP;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (timer_done) begin
                    state_next = (cnt_reg > 9'd1) ? SETUP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg        <= OP_WREG;
            addr_reg      <= 14'd0;
            data_reg      <= 8'd0;
            cnt_reg       <= 9'd0;
            mode_reg      <= 1'b0;
            dout_reg      <= 8'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 8'd0;
        end else begin
            rsp_valid_reg <= rd_last;
            if (rd_last) begin
                rsp_data_reg <= bus.vdp_din;
            end
            if (accept) begin
                op_reg   <= cmd_op;
                addr_reg <= bus.cmd_addr;
                data_reg <= bus.cmd_data;
                cnt_reg  <= byte_count(cmd_op, bus.cmd_len);
                if (cmd_op != OP_RSVD) begin
                    mode_reg <= op_mode(cmd_op);
                    dout_reg <= port_byte(cmd_op, bus.cmd_addr, bus.cmd_data, 1'b1);
                end
            end else if ((state_reg == GAP) && timer_done) begin
                // Port byte only changes between bytes, so it is stable SETUP..GAP.
                cnt_reg <= cnt_reg - 9'd1;
                if (cnt_reg > 9'd1) begin
                    dout_reg <= port_byte(op_reg, addr_reg, data_reg, 1'b0);
                end
            end
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE) && !reset;
    assign bus.vdp_wr    = (state_reg == STROBE);
    assign bus.vdp_rd    = (state_reg == RDHOLD);
    assign bus.vdp_mode  = mode_reg;
    assign bus.vdp_dout  = dout_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
endmodule

// File: tb/tb_vdp_bus_master.sv
// Directed bench for vdp_bus_master with a small VDP port model (registers,
// address pointer, VRAM, status byte) and a strobe/response monitor.
module tb_vdp_bus_master;
    localparam int G  = 2;
    localparam int RD = 4;
    localparam int BYTE_CYC = 2 + G;
    localparam int LIMIT = 3000;

    localparam logic [2:0] C_WREG = 3'd0, C_SETW = 3'd1, C_SETR = 3'd2, C_WDATA = 3'd3,
                           C_RDATA = 3'd4, C_RSTAT = 3'd5, C_FILL = 3'd6, C_RSVD = 3'd7;
    localparam logic [7:0] STATUS = 8'hC3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vdp_bus_master_if bus();

    vdp_bus_master #(.GAP_CYCLES(G), .RD_CYCLES(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    bit   [7:0]  vram [16384];
    logic [7:0]  regs [8];
    logic [13:0] ptr = 14'd0;
    logic [7:0]  latch_b = 8'd0;
    logic        latch_full = 1'b0;
    logic [8:0]  wr_q [$];
    logic [7:0]  rsp_q [$];
    int          rd_run = 0;
    int          last_rd_width = 0;
    int          overlap = 0;
    logic        rd_mode_last = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    assign bus.vdp_din = bus.vdp_mode ? STATUS : vram[ptr];

    // VDP model and monitor, sampled on the active edge.
    always @(posedge clk) begin
        if (reset) latch_full = 1'b0;
        if (bus.vdp_wr && bus.vdp_rd) overlap++;
        if (bus.vdp_wr) begin
            wr_q.push_back({bus.vdp_mode, bus.vdp_dout});
            if (bus.vdp_mode) begin
                if (!latch_full) begin
                    latch_b    = bus.vdp_dout;
                    latch_full = 1'b1;
                end else begin
                    latch_full = 1'b0;
                    if (bus.vdp_dout[7]) regs[bus.vdp_dout[2:0]] = latch_b;
                    else ptr = {bus.vdp_dout[5:0], latch_b};
                end
            end else begin
                vram[ptr]  = bus.vdp_dout;
                ptr        = ptr + 14'd1;
                latch_full = 1'b0;
            end
        end
        if (bus.vdp_rd) begin
            rd_run++;
            rd_mode_last = bus.vdp_mode;
        end else if (rd_run != 0) begin
            last_rd_width = rd_run;
            rd_run = 0;
            if (!rd_mode_last) ptr = ptr + 14'd1;
        end
        if (bus.rsp_valid) rsp_q.push_back(bus.rsp_data);
    end

    // Issues one command; lat = edges from accept until cmd_ready is seen again,
    // first_wr = edge index at which vdp_wr is first seen high (-1 if never).
    task automatic do_cmd(input logic [2:0] op, input logic [13:0] addr,
                          input logic [7:0] data, input logic [7:0] len,
                          output int lat, output int first_wr);
        int n;
        first_wr = -1;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < LIMIT) begin
            if (bus.vdp_wr && first_wr < 0) first_wr = n;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = (n >= LIMIT) ? -1 : n;
        $display("cmd op=%0d addr=%h data=%h len=%0d lat=%0d first_wr=%0d",
                 op, addr, data, len, lat, first_wr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++; if (bus.cmd_ready !== 1'b0) begin $display("FAIL rst_cmd_ready: got %b expected 0", bus.cmd_ready); mismatched++; end
        compared++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); mismatched++; end
        compared++; if (bus.rsp_data !== 8'h00) begin $display("FAIL rst_rsp_data: got %h expected 00", bus.rsp_data); mismatched++; end
        compared++; if (bus.vdp_mode !== 1'b0) begin $display("FAIL rst_vdp_mode: got %b expected 0", bus.vdp_mode); mismatched++; end
        compared++; if (bus.vdp_dout !== 8'h00) begin $display("FAIL rst_vdp_dout: got %h expected 00", bus.vdp_dout); mismatched++; end
        compared++; if (bus.vdp_wr !== 1'b0) begin $display("FAIL rst_vdp_wr: got %b expected 0", bus.vdp_wr); mismatched++; end
        compared++; if (bus.vdp_rd !== 1'b0) begin $display("FAIL rst_vdp_rd: got %b expected 0", bus.vdp_rd); mismatched++; end
        reset = 1'b0;
        @(negedge clk);
        compared++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %b expected 1", bus.cmd_ready); mismatched++; end
    endtask

    task automatic test_wreg();
        int lat, fw;
        wr_q.delete();
        do_cmd(C_WREG, 14'h0001, 8'hEA, 8'd0, lat, fw);
        compared++; if (wr_q.size() !== 2) begin $display("FAIL wreg_count: got %0d expected 2", wr_q.size()); mismatched++; end
        compared++; if ({wr_q[0], wr_q[1]} !== {9'h1EA, 9'h181}) begin $display("FAIL wreg_bytes: got %h %h expected 1ea 181", wr_q[0], wr_q[1]); mismatched++; end
        compared++; if (lat !== 2 * BYTE_CYC) begin $display("FAIL wreg_latency: got %0d expected %0d", lat, 2 * BYTE_CYC); mismatched++; end
        compared++; if (regs[1] !== 8'hEA) begin $display("FAIL wreg_model_reg1: got %h expected ea", regs[1]); mismatched++; end
    endtask

    task automatic test_setw_wdata();
        int lat, fw;
        wr_q.delete();
        do_cmd(C_SETW, 14'h1234, 8'h00, 8'd0, lat, fw);
        compared++; if (lat !== 2 * BYTE_CYC) begin $display("FAIL setw_latency: got %0d expected %0d", lat, 2 * BYTE_CYC); mismatched++; end
        do_cmd(C_WDATA, 14'h0000, 8'h5A, 8'd0, lat, fw);
        compared++; if (lat !== BYTE_CYC) begin $display("FAIL wdata_latency: got %0d expected %0d", lat, BYTE_CYC); mismatched++; end
        compared++; if (fw !== 1) begin $display("FAIL wdata_strobe_cycle: got %0d expected 1", fw); mismatched++; end
        do_cmd(C_WDATA, 14'h0000, 8'hEE, 8'd0, lat, fw);
        compared++; if (wr_q.size() !== 4) begin $display("FAIL setw_count: got %0d expected 4", wr_q.size()); mismatched++; end
        compared++; if ({wr_q[0], wr_q[1], wr_q[2], wr_q[3]} !== {9'h134, 9'h152, 9'h05A, 9'h0EE}) begin
            $display("FAIL setw_bytes: got %h %h %h %h expected 134 152 05a 0ee", wr_q[0], wr_q[1], wr_q[2], wr_q[3]); mismatched++; end
        compared++; if (vram[14'h1234] !== 8'h5A) begin $display("FAIL vram_1234: got %h expected 5a", vram[14'h1234]); mismatched++; end
        compared++; if (vram[14'h1235] !== 8'hEE) begin $display("FAIL vram_1235: got %h expected ee", vram[14'h1235]); mismatched++; end
    endtask

    task automatic test_read();
        int lat, fw;
        wr_q.delete();
        rsp_q.delete();
        do_cmd(C_SETR, 14'h1234, 8'h00, 8'd0, lat, fw);
        compared++; if ({wr_q[0], wr_q[1]} !== {9'h134, 9'h112}) begin $display("FAIL setr_bytes: got %h %h expected 134 112", wr_q[0], wr_q[1]); mismatched++; end
        last_rd_width = 0;
        do_cmd(C_RDATA, 14'h0000, 8'h00, 8'd0, lat, fw);
        compared++; if (lat !== 1 + RD + G) begin $display("FAIL rdata_latency: got %0d expected %0d", lat, 1 + RD + G); mismatched++; end
        compared++; if (last_rd_width !== RD) begin $display("FAIL rdata1_width: got %0d expected %0d", last_rd_width, RD); mismatched++; end
        compared++; if (rd_mode_last !== 1'b0) begin $display("FAIL rdata_mode: got %b expected 0", rd_mode_last); mismatched++; end
        compared++; if (fw !== -1) begin $display("FAIL rdata_no_wr: got %0d expected -1", fw); mismatched++; end
        last_rd_width = 0;
        do_cmd(C_RDATA, 14'h0000, 8'h00, 8'd0, lat, fw);
        compared++; if (last_rd_width !== RD) begin $display("FAIL rdata2_width: got %0d expected %0d", last_rd_width, RD); mismatched++; end
        compared++; if (rsp_q.size() !== 2) begin $display("FAIL rdata_rsp_count: got %0d expected 2", rsp_q.size()); mismatched++; end
        compared++; if ({rsp_q[0], rsp_q[1]} !== {8'h5A, 8'hEE}) begin $display("FAIL rdata_values: got %h %h expected 5a ee", rsp_q[0], rsp_q[1]); mismatched++; end
        compared++; if (bus.rsp_data !== 8'hEE) begin $display("FAIL rsp_data_hold: got %h expected ee", bus.rsp_data); mismatched++; end
    endtask

    task automatic test_rstat();
        int lat, fw;
        rsp_q.delete();
        last_rd_width = 0;
        do_cmd(C_RSTAT, 14'h0000, 8'h00, 8'd0, lat, fw);
        compared++; if (rd_mode_last !== 1'b1) begin $display("FAIL rstat_mode: got %b expected 1", rd_mode_last); mismatched++; end
        compared++; if (last_rd_width !== RD) begin $display("FAIL rstat_width: got %0d expected %0d", last_rd_width, RD); mismatched++; end
        compared++; if (rsp_q.size() !== 1) begin $display("FAIL rstat_rsp_count: got %0d expected 1", rsp_q.size()); mismatched++; end
        compared++; if (rsp_q[0] !== STATUS) begin $display("FAIL rstat_value: got %h expected %h", rsp_q[0], STATUS); mismatched++; end
    endtask

    task automatic test_fill();
        int lat, fw;
        logic [8:0] acc;
        do_cmd(C_SETW, 14'h0100, 8'h00, 8'd0, lat, fw);
        wr_q.delete();
        do_cmd(C_FILL, 14'h0000, 8'h00, 8'd0, lat, fw);
        acc = 9'd0;
        foreach (wr_q[i]) acc = acc | wr_q[i];
        compared++; if (wr_q.size() !== 256) begin $display("FAIL fill256_count: got %0d expected 256", wr_q.size()); mismatched++; end
        compared++; if (acc !== 9'h000) begin $display("FAIL fill256_mode_data: got %h expected 000", acc); mismatched++; end
        compared++; if (lat !== 256 * BYTE_CYC) begin $display("FAIL fill256_latency: got %0d expected %0d", lat, 256 * BYTE_CYC); mismatched++; end
        wr_q.delete();
        do_cmd(C_FILL, 14'h0000, 8'h77, 8'd32, lat, fw);
        compared++; if (wr_q.size() !== 32) begin $display("FAIL fill32_count: got %0d expected 32", wr_q.size()); mismatched++; end
        compared++; if (vram[14'h021F] !== 8'h77) begin $display("FAIL fill32_last: got %h expected 77", vram[14'h021F]); mismatched++; end
        compared++; if (vram[14'h0220] !== 8'h00) begin $display("FAIL fill32_past_end: got %h expected 00", vram[14'h0220]); mismatched++; end
    endtask

    task automatic test_reserved();
        int lat, fw;
        wr_q.delete();
        rsp_q.delete();
        do_cmd(C_RSVD, 14'h0000, 8'hFF, 8'd0, lat, fw);
        repeat (4) @(negedge clk);
        compared++; if (lat !== 0) begin $display("FAIL rsvd_latency: got %0d expected 0", lat); mismatched++; end
        compared++; if (wr_q.size() + rsp_q.size() + rd_run !== 0) begin $display("FAIL rsvd_activity: got %0d expected 0", wr_q.size() + rsp_q.size() + rd_run); mismatched++; end
    endtask

    task automatic test_back_to_back();
        int lat, fw, n;
        do_cmd(C_SETW, 14'h0300, 8'h00, 8'd0, lat, fw);
        wr_q.delete();
        bus.cmd_op    = C_WDATA;
        bus.cmd_data  = 8'h11;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_data = 8'h22;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("cmd back-to-back WDATA 11,22 done after %0d cycles", n);
        compared++; if (wr_q.size() !== 2) begin $display("FAIL b2b_count: got %0d expected 2", wr_q.size()); mismatched++; end
        compared++; if ({wr_q[0], wr_q[1]} !== {9'h011, 9'h022}) begin $display("FAIL b2b_bytes: got %h %h expected 011 022", wr_q[0], wr_q[1]); mismatched++; end
        compared++; if ({vram[14'h0300], vram[14'h0301]} !== 16'h1122) begin $display("FAIL b2b_vram: got %h%h expected 1122", vram[14'h0300], vram[14'h0301]); mismatched++; end
    endtask

    task automatic test_reset_abort();
        int n_wr, k, rsp_before;
        @(negedge clk);
        bus.cmd_op    = C_SETW;
        bus.cmd_addr  = 14'h0ABC;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_wr = 0;
        k = 0;
        while (k < 50) begin
            if (bus.vdp_wr) begin
                n_wr++;
                if (n_wr == 2) break;
            end
            @(negedge clk);
            k++;
        end
        compared++; if (n_wr !== 2) begin $display("FAIL abort_second_strobe: got %0d expected 2", n_wr); mismatched++; end
        rsp_before = rsp_q.size();
        reset = 1'b1;
        @(negedge clk);
        compared++; if (bus.vdp_wr !== 1'b0) begin $display("FAIL abort_wr_off: got %b expected 0", bus.vdp_wr); mismatched++; end
        compared++; if ({bus.vdp_mode, bus.vdp_dout, bus.cmd_ready} !== 10'd0) begin
            $display("FAIL abort_outputs: got %b expected 0", {bus.vdp_mode, bus.vdp_dout, bus.cmd_ready}); mismatched++; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL abort_ready_after: got %b expected 1", bus.cmd_ready); mismatched++; end
        repeat (8) @(negedge clk);
        compared++; if (rsp_q.size() !== rsp_before) begin $display("FAIL abort_no_rsp: got %0d expected %0d", rsp_q.size(), rsp_before); mismatched++; end
        compared++; if (bus.vdp_wr !== 1'b0) begin $display("FAIL abort_stays_idle: got %b expected 0", bus.vdp_wr); mismatched++; end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 14'd0;
        bus.cmd_data  = 8'd0;
        bus.cmd_len   = 8'd0;
        test_reset();
        test_wreg();
        test_setw_wdata();
        test_read();
        test_rstat();
        test_fill();
        test_reserved();
        test_back_to_back();
        test_reset_abort();
        compared++; if (overlap !== 0) begin $display("FAIL wr_rd_overlap: got %0d expected 0", overlap); mismatched++; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
